i2c_reg_write_ctrl: RTL and testbench
=====================================

Name: i2c_reg_write_ctrl

Overview:
- Sequences one I2C register-write transaction (START, device address + W, register address, data byte, STOP) onto open-drain SCL/SDA.
- Lets the board top push values (e.g. seconds/minutes count) to an external I2C peripheral.
- Timing is taken from an external tick strobe, such as the 1 us pulse from the shared pulse generator, so the block holds no frequency constants.

Parameters:
- QUARTER_TICKS, 1: tick pulses per quarter SCL period (tick = 1 us gives SCL = 250 kHz).
- ABORT_ON_NACK, 1: 1 = on NACK go directly to STOP; 0 = finish all bytes and only flag the NACK.

Ports:
- clk  in  1  system clock (84 MHz PLL output)
- rst  in  1  asynchronous reset, active-high
- tick  in  1  single-cycle timing strobe
- start  in  1  request strobe; sampled only while idle
- dev_addr  in  7  7-bit slave address
- reg_addr  in  8  register address byte
- wr_data  in  8  data byte
- scl_in  in  1  SCL pin readback
- sda_in  in  1  SDA pin readback
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- nack  out  1  a NACK was seen in the last transaction

Behaviour:
- Reset (async, immediate): scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, state IDLE, quarter/bit/byte counters 0. Reset mid-transaction releases both lines at once; no STOP is generated.
- Accept: in IDLE, start=1 at a clk edge latches dev_addr, reg_addr and wr_data, clears nack, and sets busy=1 on the next cycle. start is ignored while busy. Inputs may change after acceptance.
- Quarter timer: advances one quarter per QUARTER_TICKS tick pulses. All line changes occur only on the cycle a quarter completes.
- States: IDLE -> START -> BYTE -> ACK -> (BYTE | STOP) -> DONE -> IDLE.
- START (4 quarters):
  - Q0 and Q1: both lines released.
  - Q2: sda_oe=1.
  - Q3: scl_oe=1.
- BYTE (8 bits x 4 quarters, MSB first):
  - Q0: scl_oe=1, sda_oe=~bit.
  - Q1 and Q2: scl_oe=0.
  - Q3: scl_oe=1.
- Byte order: byte0 = {dev_addr, 1'b0}, byte1 = reg_addr, byte2 = wr_data.
- ACK (4 quarters): SDA released; SCL low/high/high/low as in BYTE. sda_in is sampled on the cycle Q1 completes; sda_in=1 means NACK and sets nack=1.
- After ACK:
  - Byte index < 2 and no abort: go to BYTE with the next byte.
  - Otherwise: go to STOP.
  - On NACK with ABORT_ON_NACK=1: go straight to STOP.
- STOP (4 quarters):
  - Q0: scl_oe=1, sda_oe=1.
  - Q1 and Q2: scl_oe=0, sda_oe=1.
  - Q3: sda_oe=0.
- DONE: one clk cycle with done=1 and busy=0, then IDLE. A start arriving in the DONE cycle is ignored.
- Nominal length: 4 + 3 x (32 + 4) + 4 = 116 quarters from acceptance to done.
- tick asserted continuously (QUARTER_TICKS=1) gives 1 quarter per clk cycle. This is legal and used in simulation.
- Counter widths: quarter 2 bits, bit 3 bits, byte 2 bits, tick divider $clog2(QUARTER_TICKS+1) bits.

Optional Feature:
- I2C_CLK_STRETCH_EN defined: in any quarter where scl_oe=0 (SCL released), the quarter does not complete while scl_in=0. The timer freezes and the tick count is held; the slave's clock stretching is honoured.
- Undefined: scl_in is ignored and quarters complete on tick count alone.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_state_e {IDLE, START, BYTE, ACK, STOP, DONE}
  - localparam I2C_WR = 1'b0
  - localparam I2C_NUM_BYTES = 3
- One sub-module: i2c_quarter_timer (tick divider + 2-bit quarter counter, stall input for clock stretch). Outputs quarter index and quarter_end strobe.

Test Plan:
- dev_addr=7'h3C, reg_addr=8'h01, wr_data=8'h2A, QUARTER_TICKS=1, slave ACKs all bytes -> SDA bits sampled at SCL high read 0x78, 0x01, 0x2A; START/STOP edges correct; done after 116 quarters; nack=0.
- Same request with slave NACK on byte0, ABORT_ON_NACK=1 -> STOP follows the first ACK slot; nack=1; done pulses; only 9 SCL high pulses seen.
- ABORT_ON_NACK=0, NACK on byte1 -> all 27 SCL pulses occur; nack=1 stays until the next accepted start.
- start re-pulsed while busy, and again in the DONE cycle -> both ignored; exactly one transaction occurs.
- rst asserted mid-byte1 -> scl_oe=0, sda_oe=0 and busy=0 in the same cycle; a new start then runs a clean full transaction.
- With I2C_CLK_STRETCH_EN: slave holds scl_in=0 for 10 cycles in bit 3 of byte1 -> no SDA/SCL output change during the hold; total length grows by exactly 10 cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write controller.
// Byte selection helper keeps the wire order in one place.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP,
    DONE
  } i2c_state_e;

  localparam logic I2C_WR        = 1'b0;
  localparam int   I2C_NUM_BYTES = 3;

  function automatic logic [7:0] i2c_byte(
    input logic [1:0] idx,
    input logic [6:0] dev,
    input logic [7:0] ra,
    input logic [7:0] dat
  );
    logic [7:0] b;
    b = dat;
    if (idx == 2'd0) b = {dev, I2C_WR};
    else if (idx == 2'd1) b = ra;
    return b;
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Tick divider plus 2-bit quarter counter for SCL phase timing.
// A stall freezes both the tick count and the quarter index.
module i2c_quarter_timer #(
  parameter int QUARTER_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       tick,
  input  logic       stall,
  output logic [1:0] quarter,
  output logic       quarter_end
);

  localparam int TW = $clog2(QUARTER_TICKS + 1);
  localparam logic [TW-1:0] TLAST = TW'(QUARTER_TICKS - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [1:0]    qtr_q, qtr_d;

  assign quarter_end = run & tick & ~stall & (tcnt_q == TLAST);
  assign quarter     = qtr_q;

  always_comb begin
    tcnt_d = tcnt_q;
    qtr_d  = qtr_q;
    if (!run) begin
      tcnt_d = '0;
      qtr_d  = '0;
    end else if (quarter_end) begin
      tcnt_d = '0;
      qtr_d  = qtr_q + 2'd1;
    end else if (tick && !stall) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      qtr_q  <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      qtr_q  <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_reg_write_ctrl.sv
// Single I2C register write: START, addr+W, reg, data, STOP on open-drain lines.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on released SCL.
module i2c_reg_write_ctrl
  import i2c_pkg::*;
#(
  parameter int QUARTER_TICKS = 1,
  parameter bit ABORT_ON_NACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam logic [1:0] LAST_BYTE = 2'(I2C_NUM_BYTES - 1);

  i2c_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] dat_q, dat_d;
  logic       nack_q, nack_d;

  logic       run;
  logic       stall;
  logic [1:0] qtr;
  logic       qend;
  logic [7:0] cur_byte;
  logic       cur_bit;

  assign run = state_q inside {START, BYTE, ACK, STOP};

`ifdef I2C_CLK_STRETCH_EN
  assign stall = ~scl_oe & ~scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  i2c_quarter_timer #(
    .QUARTER_TICKS(QUARTER_TICKS)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .tick       (tick),
    .stall      (stall),
    .quarter    (qtr),
    .quarter_end(qend)
  );

  assign cur_byte = i2c_byte(byte_q, dev_q, reg_q, dat_q);
  assign cur_bit  = cur_byte[3'd7 - bit_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    nack_d  = nack_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          dev_d   = dev_addr;
          reg_d   = reg_addr;
          dat_d   = wr_data;
          nack_d  = 1'b0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      START: begin
        if (qend && qtr == 2'd3) state_d = BYTE;
      end
      BYTE: begin
        if (qend && qtr == 2'd3) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ACK: begin
        if (qend && qtr == 2'd1 && sda_in) nack_d = 1'b1;
        // nack_q already reflects this slot's sample by Q3
        if (qend && qtr == 2'd3) begin
          if ((ABORT_ON_NACK && nack_q) || byte_q == LAST_BYTE) begin
            state_d = STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = BYTE;
          end
        end
      end
      STOP: begin
        if (qend && qtr == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    busy   = run;
    done   = (state_q == DONE);
    nack   = nack_q;
    unique case (state_q)
      START: begin
        sda_oe = qtr[1];
        scl_oe = (qtr == 2'd3);
      end
      BYTE: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe = ~cur_bit;
      end
      ACK: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
      end
      STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = (qtr != 2'd3);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_write_ctrl.sv
// Bench for i2c_reg_write_ctrl: two instances (abort / no-abort) checked
// against a bus-level slave model and a transaction-length model.
module tb_i2c_reg_write_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wr_data = '0;

  logic a_scl_oe, a_sda_oe, a_busy, a_done, a_nack, a_scl_in, a_sda_in;
  logic b_scl_oe, b_sda_oe, b_busy, b_done, b_nack, b_scl_in, b_sda_in;
  logic [1:0] pull = '0;
  logic [1:0] hold = '0;

  assign a_sda_in = ~a_sda_oe & ~pull[0];
  assign a_scl_in = ~a_scl_oe & ~hold[0];
  assign b_sda_in = ~b_sda_oe & ~pull[1];
  assign b_scl_in = ~b_scl_oe & ~hold[1];

  i2c_reg_write_ctrl #(.QUARTER_TICKS(1), .ABORT_ON_NACK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .scl_in(a_scl_in), .sda_in(a_sda_in),
    .scl_oe(a_scl_oe), .sda_oe(a_sda_oe),
    .busy(a_busy), .done(a_done), .nack(a_nack)
  );

  i2c_reg_write_ctrl #(.QUARTER_TICKS(1), .ABORT_ON_NACK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
    .scl_in(b_scl_in), .sda_in(b_sda_in),
    .scl_oe(b_scl_oe), .sda_oe(b_sda_oe),
    .busy(b_busy), .done(b_done), .nack(b_nack)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // stimulus configuration read by the model
  int nack_byte = -1;
  int stretch_len = 0;

  // transaction model
  bit         act[2];
  int         cyc[2], nexp[2], blen[2], sent[2], ntx[2];
  logic       nack_exp[2];
  logic [7:0] xb[2][3];
  // bus observer / slave
  logic       pscl[2], psda[2];
  logic [1:0] poe[2];
  int         bitcnt[2], pulses[2], starts[2], stops[2], rxn[2], hcnt[2];
  logic [7:0] sh[2];
  logic [7:0] rx[2][3];
  bit         hi[2], arm[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; ntx[i] = 0; blen[i] = 0; nack_exp[i] = 0;
      pscl[i] = 1; psda[i] = 1; poe[i] = '0; arm[i] = 0; hcnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    logic o_scl, o_sda, o_busy, o_done, o_nack, scl_l, sda_l;
    bit jd;
    for (int i = 0; i < 2; i++) begin
      o_scl  = (i == 0) ? a_scl_oe : b_scl_oe;
      o_sda  = (i == 0) ? a_sda_oe : b_sda_oe;
      o_busy = (i == 0) ? a_busy : b_busy;
      o_done = (i == 0) ? a_done : b_done;
      o_nack = (i == 0) ? a_nack : b_nack;
      if (rst) begin
        act[i] = 0; nack_exp[i] = 0; pull[i] = 0; hold[i] = 0; arm[i] = 0;
        pscl[i] = 1; psda[i] = 1; poe[i] = '0;
        chk("rst_out", {o_scl, o_sda, o_busy, o_done, o_nack}, 0);
      end else begin
        jd = 0;
        if (hold[i]) begin
          if (hcnt[i] == 0) hold[i] = 0;
          else hcnt[i]--;
        end else if (arm[i]) begin
          hold[i] = 1; hcnt[i] = stretch_len; arm[i] = 0;
        end
        if (hold[i] && hcnt[i] <= stretch_len - 2)
          chk("stretch_freeze", {o_scl, o_sda}, poe[i]);
        scl_l = ~o_scl & ~hold[i];
        sda_l = ~o_sda & ~pull[i];
        if (pscl[i] && scl_l && psda[i] && !sda_l) begin
          starts[i]++; bitcnt[i] = 0;
        end
        if (pscl[i] && scl_l && !psda[i] && sda_l) stops[i]++;
        if (!pscl[i] && scl_l) begin
          hi[i] = 1;
          bitcnt[i]++;
          if (bitcnt[i] % 9 != 0) begin
            sh[i] = {sh[i][6:0], sda_l};
            if (bitcnt[i] % 9 == 8 && rxn[i] < 3) begin
              rx[i][rxn[i]] = sh[i];
              rxn[i]++;
            end
          end
        end
        if (pscl[i] && !scl_l) begin
          if (hi[i]) pulses[i]++;
          hi[i] = 0;
          if (bitcnt[i] % 9 == 8) pull[i] = (bitcnt[i] / 9 != nack_byte);
          if (bitcnt[i] % 9 == 0 && bitcnt[i] > 0) pull[i] = 0;
          if (stretch_len > 0 && bitcnt[i] == 12) arm[i] = 1;
        end
        pscl[i] = scl_l;
        psda[i] = sda_l;
        poe[i]  = {o_scl, o_sda};
        if (o_busy) blen[i]++;
        if (act[i]) begin
          cyc[i]++;
          chk("busy", o_busy, cyc[i] <= nexp[i]);
          chk("done", o_done, cyc[i] == nexp[i] + 1);
          if (cyc[i] == 1) chk("nack_clr", o_nack, 0);
          if (cyc[i] == nexp[i] + 1) begin
            chk("nack_end", o_nack, nack_exp[i]);
            chk("nbytes", rxn[i], sent[i]);
            for (int k = 0; k < 3; k++)
              if (k < sent[i]) chk("rx_byte", rx[i][k], xb[i][k]);
            chk("pulses", pulses[i], 9 * sent[i]);
            chk("starts", starts[i], 1);
            chk("stops", stops[i], 1);
            chk("lines_done", {o_scl, o_sda}, 0);
            act[i] = 0; jd = 1; ntx[i]++;
          end
        end else begin
          chk("idle_out", {o_scl, o_sda, o_busy, o_done}, 0);
          chk("idle_nack", o_nack, nack_exp[i]);
        end
        if (start && !act[i] && !jd) begin
          act[i] = 1; cyc[i] = 0; blen[i] = 0;
          sent[i] = (i == 0 && nack_byte >= 0 && nack_byte < 3) ?
                    nack_byte + 1 : 3;
          nexp[i] = 8 + 36 * sent[i] + stretch_len;
          nack_exp[i] = (nack_byte >= 0);
          xb[i][0] = {dev_addr, 1'b0};
          xb[i][1] = reg_addr;
          xb[i][2] = wr_data;
          pulses[i] = 0; starts[i] = 0; stops[i] = 0; rxn[i] = 0;
          bitcnt[i] = 0; hi[i] = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic scramble();
    dev_addr = 7'($urandom);
    reg_addr = 8'($urandom);
    wr_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("timeout", n < 400, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic run_txn(input logic [6:0] d, input logic [7:0] r,
                         input logic [7:0] w, input int nb);
    nack_byte = nb;
    dev_addr = d; reg_addr = r; wr_data = w;
    pulse_start();
    scramble();
    wait_done();
  endtask

  initial begin
    int n, t0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // full write, all bytes acknowledged
    run_txn(7'h3C, 8'h01, 8'h2A, -1);
    chk("t1_len", blen[0], 116);
    chk("t1_b0", rx[0][0], 8'h78);
    chk("t1_b1", rx[0][1], 8'h01);
    chk("t1_b2", rx[0][2], 8'h2A);
    chk("t1_pulses", pulses[1], 27);
    chk("t1_nack", a_nack, 0);

    // NACK on address byte
    run_txn(7'h3C, 8'h01, 8'h2A, 0);
    chk("t2_abort_len", blen[0], 44);
    chk("t2_abort_pulses", pulses[0], 9);
    chk("t2_abort_nack", a_nack, 1);
    chk("t2_cont_len", blen[1], 116);

    // NACK on register byte
    run_txn(7'h51, 8'hA5, 8'h0F, 1);
    chk("t3_cont_pulses", pulses[1], 27);
    chk("t3_cont_nack", b_nack, 1);
    chk("t3_abort_pulses", pulses[0], 18);
    repeat (10) @(posedge clk);
    chk("t3_nack_hold", {a_nack, b_nack}, 2'b11);

    // start while busy and in the DONE cycle
    t0 = ntx[0];
    nack_byte = -1;
    dev_addr = 7'h12; reg_addr = 8'h34; wr_data = 8'h56;
    pulse_start();
    repeat (20) @(posedge clk);
    dev_addr = 7'h7F;
    pulse_start();
    n = 0;
    while (!a_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t4_done_seen", a_done, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    chk("t4_one_txn", ntx[0] - t0, 1);
    chk("t4_rx0", rx[0][0], 8'h24);
    chk("t4_idle", {a_busy, b_busy}, 0);

    // reset in the middle of byte1
    dev_addr = 7'h3C; reg_addr = 8'h01; wr_data = 8'h2A;
    pulse_start();
    repeat (55) @(posedge clk);
    chk("t5_busy_before", a_busy, 1);
    #2 rst = 1'b1;
    #1 chk("t5_async", {a_scl_oe, a_sda_oe, a_busy,
                        b_scl_oe, b_sda_oe, b_busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_txn(7'h3C, 8'h01, 8'h2A, -1);
    chk("t5_len", blen[0], 116);
    chk("t5_b2", rx[0][2], 8'h2A);

`ifdef I2C_CLK_STRETCH_EN
    // slave holds SCL low for 10 cycles in bit 3 of byte1
    stretch_len = 10;
    run_txn(7'h3C, 8'h01, 8'h2A, -1);
    chk("t6_len", blen[0], 126);
    chk("t6_b1", rx[0][1], 8'h01);
    stretch_len = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
